// File: rtl/decode.sv
// Fetch-to-decode queue with combinational decode of the head entry.
// Optional build macro DECODE_ILLEGAL_EN flags unrecognised opcodes as illegal.
package decode_pkg;

    typedef struct packed {
        logic        fault_page;
        logic        fault;
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    localparam logic [2:0] OPC_ALU    = 3'd0;
    localparam logic [2:0] OPC_LSU    = 3'd1;
    localparam logic [2:0] OPC_BRANCH = 3'd2;
    localparam logic [2:0] OPC_SYSTEM = 3'd3;
    localparam logic [2:0] OPC_MULDIV = 3'd4;
    localparam logic [2:0] OPC_NONE   = 3'd7;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

endpackage

module decode
    import decode_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_valid_i,
    input  logic [31:0] f_instr_i,
    input  logic [31:0] f_pc_i,
    input  logic        f_fault_i,
    input  logic        f_fault_page_i,
    output logic        f_accept_o,
    input  logic        squash_decode_i,
    output logic        d_valid_o,
    input  logic        d_accept_i,
    output logic [31:0] d_instr_o,
    output logic [31:0] d_pc_o,
    output logic        d_fault_o,
    output logic        d_fault_page_o,
    output logic [2:0]  d_opclass_o,
    output logic [4:0]  d_rd_o,
    output logic [4:0]  d_ra_o,
    output logic [4:0]  d_rb_o,
    output logic        d_illegal_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    assign f_accept_o = (count != CNT_W'(DEPTH));
    assign d_valid_o  = (count != '0);
    assign push       = f_valid_i && f_accept_o && !squash_decode_i;
    assign pop        = d_valid_o && d_accept_i && !squash_decode_i;

    // Queue pointers and occupancy; squash wins over any same-cycle push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (squash_decode_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage is not reset; reads are gated by d_valid_o.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{fault_page: f_fault_page_i, fault: f_fault_i,
                             pc: f_pc_i, instr: f_instr_i};
        end
    end

    fq_entry_t  head;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [2:0] cls;
    logic       rd_zero;
    logic       faulted;

    // Decode of the head entry.
    always_comb begin
        head    = mem[rd_ptr];
        opcode  = head.instr[6:0];
        funct3  = head.instr[14:12];
        funct7  = head.instr[31:25];
        faulted = head.fault | head.fault_page;
        cls     = OPC_NONE;
        rd_zero = 1'b0;

        d_instr_o      = '0;
        d_pc_o         = '0;
        d_fault_o      = 1'b0;
        d_fault_page_o = 1'b0;
        d_opclass_o    = OPC_NONE;
        d_rd_o         = '0;
        d_ra_o         = '0;
        d_rb_o         = '0;
        d_illegal_o    = 1'b0;

        case (opcode)
            OP_LUI, OP_AUIPC, OP_IMM, OP_MISC_MEM: cls = OPC_ALU;
            OP_OP:      cls = (funct7 == 7'b0000001) ? OPC_MULDIV : OPC_ALU;
            OP_LOAD:    cls = OPC_LSU;
            OP_STORE: begin
                cls     = OPC_LSU;
                rd_zero = 1'b1;
            end
            OP_BRANCH: begin
                cls     = OPC_BRANCH;
                rd_zero = 1'b1;
            end
            OP_JAL, OP_JALR: cls = OPC_BRANCH;
            OP_SYSTEM: begin
                cls     = OPC_SYSTEM;
                rd_zero = (funct3 == 3'b000);
            end
            default:    cls = OPC_NONE;
        endcase

        if (d_valid_o) begin
            d_instr_o      = head.instr;
            d_pc_o         = head.pc;
            d_fault_o      = head.fault;
            d_fault_page_o = head.fault_page;
            if (!faulted) begin
`ifdef DECODE_ILLEGAL_EN
                d_opclass_o = cls;
                d_illegal_o = (cls == OPC_NONE);
`else
                d_opclass_o = (cls == OPC_NONE) ? OPC_ALU : cls;
`endif
                d_rd_o = rd_zero ? 5'd0 : head.instr[11:7];
                d_ra_o = head.instr[19:15];
                d_rb_o = head.instr[24:20];
            end
        end
    end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
- REQ-001 SHALL have parameter: DEPTH, 2, entries in fetch-to-decode queue (power of two, >=2).
- REQ-002 SHALL have port: clk  in  1  clock, all state updates on rising edge.
- REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-low.
- REQ-004 SHALL have port: f_valid_i  in  1  fetched instruction valid.
- REQ-005 SHALL have port: f_instr_i  in  32  fetched instruction word.
- REQ-006 SHALL have port: f_pc_i  in  32  PC of fetched instruction.
- REQ-007 SHALL have port: f_fault_i  in  1  fetch bus error.
- REQ-008 SHALL have port: f_fault_page_i  in  1  fetch page fault.
- REQ-009 SHALL have port: f_accept_o  out  1  decode can take an instruction this cycle.
- REQ-010 SHALL have port: squash_decode_i  in  1  flush all queued instructions.
- REQ-011 SHALL have port: d_valid_o  out  1  decoded instruction valid.
- REQ-012 SHALL have port: d_accept_i  in  1  issue consumes head this cycle.
- REQ-013 SHALL have ports: d_instr_o 32, d_pc_o 32, d_fault_o 1, d_fault_page_o 1  out  head entry fields.
- REQ-014 SHALL have ports: d_opclass_o 3, d_rd_o 5, d_ra_o 5, d_rb_o 5, d_illegal_o 1  out  decode of head.

Function
- REQ-015 SHALL hold a DEPTH-entry FIFO of {fault_page, fault, pc, instr}; read/write pointers wrap modulo DEPTH; count 0..DEPTH.
- REQ-016 SHALL drive f_accept_o = (count != DEPTH), from registered count only; no push when full even if a pop occurs same cycle.
- REQ-017 SHALL push when f_valid_i && f_accept_o && !squash_decode_i; data visible at d_* the next cycle (1-cycle latency).
- REQ-018 SHALL drive d_valid_o = (count != 0); d_* fields combinationally from head entry; pop when d_valid_o && d_accept_i.
- REQ-019 SHALL on push and pop in the same cycle keep count unchanged, advance both pointers.
- REQ-020 SHALL on squash_decode_i clear count and set both pointers to 0 next cycle, discarding any same-cycle push and ignoring same-cycle pop.
- REQ-021 SHALL keep d_* stable while d_valid_o && !d_accept_i.
- REQ-022 SHALL decode d_opclass_o from instr[6:0]: 0 ALU (LUI, AUIPC, OP-IMM, OP with funct7!=0000001, MISC-MEM), 1 LSU (LOAD, STORE), 2 BRANCH (BRANCH, JAL, JALR), 3 SYSTEM, 4 MULDIV (OP with funct7=0000001), 7 NONE.
- REQ-023 SHALL drive d_rd_o = instr[11:7], forced 0 for STORE, BRANCH, SYSTEM with funct3=0, and faulted entries.
- REQ-024 SHALL drive d_ra_o = instr[19:15], d_rb_o = instr[24:20], both forced 0 for faulted entries.
- REQ-025 SHALL for entries with fault or fault_page set drive d_opclass_o=7, d_illegal_o=0, d_instr_o unchanged.
- REQ-026 SHALL drive d_opclass_o=7 and all d_* to 0 when d_valid_o=0.

Reset
- REQ-027 SHALL while rst=0 force count=0, pointers=0, f_accept_o=1, d_valid_o=0, all d_* outputs 0.
- REQ-028 SHALL on reset mid-operation discard all entries; first push after release appears at d_* one cycle later.
- REQ-029 SHALL not reset FIFO data storage; outputs gated by d_valid_o per REQ-026.

Configuration
- REQ-030 SHALL with DECODE_ILLEGAL_EN defined assert d_illegal_o for non-faulted entries whose instr[1:0]!=2'b11 or opcode unlisted in REQ-022, with d_opclass_o=7.
- REQ-031 SHALL with DECODE_ILLEGAL_EN undefined tie d_illegal_o=0 and class unlisted opcodes as ALU (0).

Verification
- REQ-032 SHALL cover: push 0x00500093 @pc 0x100 -> next cycle d_valid_o=1, d_opclass_o=0, d_rd_o=1, d_ra_o=0, d_pc_o=0x100.
- REQ-033 SHALL cover: d_accept_i=0, push 2 entries -> f_accept_o=0; third f_valid_i held, not captured; d_* stable; then accept -> FIFO order preserved.
- REQ-034 SHALL cover: full FIFO, squash_decode_i=1 with f_valid_i=1 -> next cycle d_valid_o=0, f_accept_o=1, pushed word discarded.
- REQ-035 SHALL cover: push 0x00112023 (SW) -> d_opclass_o=1, d_rd_o=0; push 0x02208033 -> d_opclass_o=4.
- REQ-036 SHALL cover: push with f_fault_page_i=1 -> d_fault_page_o=1, d_opclass_o=7, d_ra_o=0; push 0xFFFFFFFF with DECODE_ILLEGAL_EN -> d_illegal_o=1, without -> 0.
- REQ-037 SHALL cover: rst=0 asserted with 1 entry queued -> d_valid_o=0 immediately (async), all outputs 0.
